// File: rtl/ctrl_fetch_mc_if.sv
// Instruction-memory request/acknowledge port between the fetch/control stage and its
// instruction store.
interface ctrl_fetch_mc_if #(
   parameter int PC_W = 8
) ();
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_ack;
   logic [15:0]     imem_rdata;

   modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
   modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/ctrl_fetch_mc.sv
// Multicycle fetch/decode/sequence controller feeding the register-file/MUX/ULA datapath.
// Free-runs or single-steps; updates the PC from the ULA Zero flag for branches.
module ctrl_fetch_mc #(
   parameter int PC_W   = 8,
   parameter int DATA_W = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              run,
   input  logic              step,
   ctrl_fetch_mc_if.master   imem,
   output logic [2:0]        ra1,
   output logic [2:0]        ra2,
   output logic [2:0]        wa3,
   output logic              we3,
   output logic [2:0]        ula_control,
   output logic              alu_src,
   output logic [DATA_W-1:0] imm,
   input  logic              zero,
   output logic [PC_W-1:0]   pc,
   output logic              halted,
   output logic [7:0]        instr_count
);

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h3;
   localparam logic [3:0] OP_OR   = 4'h4;
   localparam logic [3:0] OP_SLT  = 4'h5;
   localparam logic [3:0] OP_ADDI = 4'h6;
   localparam logic [3:0] OP_BEQ  = 4'h7;
   localparam logic [3:0] OP_JMP  = 4'h8;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_WRITEBACK,
      S_HALTED
   } state_t;

   state_t      state, state_d;
   logic [15:0] ir;
   logic [3:0]  op;
   logic        ir_load;
   logic        retire;
   logic        writes_reg;
   logic [PC_W-1:0] pc_d;

   function automatic logic signed [DATA_W-1:0] sext_imm(input logic [5:0] field);
      logic signed [5:0] s;
      s = signed'(field);
      return DATA_W'(s);
   endfunction

   function automatic logic [PC_W-1:0] branch_target(input logic [PC_W-1:0] base,
                                                      input logic [5:0]      field);
      logic signed [5:0]      s;
      logic signed [PC_W-1:0] off;
      s   = signed'(field);
      off = PC_W'(s);
      return base + PC_W'(off);
   endfunction

   function automatic logic [2:0] ula_decode(input logic [3:0] opcode);
      logic [2:0] f;
      case (opcode)
         OP_ADD, OP_ADDI: f = 3'b010;
         OP_SUB, OP_BEQ:  f = 3'b110;
         OP_AND:          f = 3'b000;
         OP_OR:           f = 3'b001;
         OP_SLT:          f = 3'b111;
         default:         f = 3'b000;
      endcase
      return f;
   endfunction

   assign op         = ir[15:12];
   assign writes_reg = (op >= OP_ADD) && (op <= OP_ADDI);

   // Datapath controls decode straight from IR, so they hold from DECODE until the next fetch.
   assign ra1         = ir[8:6];
   assign ra2         = (op == OP_BEQ) ? ir[11:9] : ir[5:3];
   assign wa3         = ir[11:9];
   assign imm         = sext_imm(ir[5:0]);
   assign ula_control = ula_decode(op);
   assign alu_src     = (op == OP_ADDI);

   assign we3            = (state == S_WRITEBACK);
   assign halted         = (state == S_HALTED);
   assign imem.imem_req  = (state == S_FETCH);
   assign imem.imem_addr = pc;

   always_comb begin
      state_d = state;
      retire  = 1'b0;
      ir_load = 1'b0;
      case (state)
         S_IDLE:      if (run || step) state_d = S_FETCH;
         S_FETCH: begin
            if (imem.imem_ack) begin
               ir_load = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (op == OP_HALT)     state_d = S_HALTED;
            else if (op == OP_JMP) retire  = 1'b1;
            else                   state_d = S_EXECUTE;
         end
         S_EXECUTE: begin
            if (writes_reg) state_d = S_WRITEBACK;
            else            retire  = 1'b1;
         end
         S_WRITEBACK: retire = 1'b1;
         S_HALTED:    state_d = S_HALTED;
         default:     state_d = S_IDLE;
      endcase
      // A run 1->0 change is only honoured here, at an instruction boundary.
      if (retire) state_d = run ? S_FETCH : S_IDLE;
   end

   always_comb begin
      pc_d = pc + PC_W'(1);
      if (op == OP_JMP)             pc_d = PC_W'(ir[7:0]);
      else if (op == OP_BEQ && zero) pc_d = branch_target(pc, ir[5:0]);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         pc          <= '0;
         ir          <= '0;
         instr_count <= '0;
      end else begin
         state <= state_d;
         if (ir_load) ir <= imem.imem_rdata;
         if (retire) begin
            pc          <= pc_d;
            instr_count <= instr_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_ctrl_fetch_mc.sv
// Directed bench for ctrl_fetch_mc: per-instruction vector table in step mode plus
// hand-written free-run, wait-state, stepping, halt and reset sequences.
module tb_ctrl_fetch_mc;
   localparam int PC_W   = 8;
   localparam int DATA_W = 8;
   localparam int NV     = 15;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic run   = 1'b0;
   logic step  = 1'b0;
   logic zero  = 1'b0;
   logic [2:0] ra1, ra2, wa3, ula_control;
   logic       we3, alu_src, halted;
   logic [DATA_W-1:0] imm;
   logic [PC_W-1:0]   pc;
   logic [7:0]        instr_count;

   ctrl_fetch_mc_if #(.PC_W(PC_W)) bus ();

   ctrl_fetch_mc #(.PC_W(PC_W), .DATA_W(DATA_W)) dut (
      .clock       (clock),
      .reset       (reset),
      .run         (run),
      .step        (step),
      .imem        (bus),
      .ra1         (ra1),
      .ra2         (ra2),
      .wa3         (wa3),
      .we3         (we3),
      .ula_control (ula_control),
      .alu_src     (alu_src),
      .imm         (imm),
      .zero        (zero),
      .pc          (pc),
      .halted      (halted),
      .instr_count (instr_count)
   );

   always #5 clock = ~clock;

   // Instruction store: acks after ack_delay wait cycles, garbage data while not acking.
   logic [15:0] mem [256];
   int ack_delay = 0;
   int wcnt      = 0;

   always @(negedge clock) begin
      if (bus.imem_req) begin
         if (wcnt >= ack_delay) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = mem[bus.imem_addr];
            wcnt = 0;
         end else begin
            bus.imem_ack   = 1'b0;
            bus.imem_rdata = 16'hFFFF;
            wcnt++;
         end
      end else begin
         bus.imem_ack   = 1'b0;
         bus.imem_rdata = 16'hFFFF;
         wcnt = 0;
      end
   end

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      string      name;
      logic [7:0] start_pc;
      logic [15:0] instr;
      logic       zero;
      logic [2:0] ra1, ra2, wa3, ula;
      logic       alu_src;
      logic [7:0] imm;
      int         we_n;
      int         lat;
      logic [7:0] pc_after;
   } vec_t;

   vec_t vecs [NV];

   int         cap_lat, cap_we;
   logic       cap_done, cap_alu;
   logic [2:0] cap_ra1, cap_ra2, cap_wa3, cap_ula;
   logic [7:0] cap_imm;

   task automatic do_reset();
      reset = 1'b0;
      run   = 1'b0;
      step  = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
   endtask

   task automatic clear_mem();
      for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
   endtask

   // Issue one step pulse from IDLE and observe the instruction until it retires.
   task automatic step_instr();
      logic [7:0] base;
      int n;
      bit started;
      base = instr_count;
      n = 0;
      started = 0;
      cap_done = 0;
      cap_we = 0;
      step = 1'b1;
      for (int c = 0; c < 40 && !cap_done; c++) begin
         @(posedge clock);
         #1 step = 1'b0;
         if (instr_count != base || halted) cap_done = 1'b1;
         else begin
            if (bus.imem_req) started = 1;
            if (started) begin
               n++;
               if (n == 2) begin
                  cap_ra1 = ra1; cap_ra2 = ra2; cap_wa3 = wa3;
                  cap_ula = ula_control; cap_alu = alu_src; cap_imm = imm;
               end
               if (we3) cap_we++;
            end
         end
      end
      cap_lat = n;
   endtask

   initial begin
      logic [7:0] base;
      int first_we, second_we, we_n, halt_k, bad, req_n, early;
      logic [2:0] wa_first;
      logic [7:0] imm_first, pc5, cnt5;

      vecs[0]  = '{"addi_r1_r0_5", 8'h00, 16'h6205, 1'b0, 3'd0, 3'd0, 3'd1, 3'b010, 1'b1, 8'h05, 1, 4, 8'h01};
      vecs[1]  = '{"add_r3_r1_r2", 8'h00, 16'h1650, 1'b0, 3'd1, 3'd2, 3'd3, 3'b010, 1'b0, 8'h10, 1, 4, 8'h01};
      vecs[2]  = '{"sub_r5_r6_r7", 8'h20, 16'h2BB8, 1'b0, 3'd6, 3'd7, 3'd5, 3'b110, 1'b0, 8'hF8, 1, 4, 8'h21};
      vecs[3]  = '{"and_r2_r4_r1", 8'h00, 16'h3508, 1'b0, 3'd4, 3'd1, 3'd2, 3'b000, 1'b0, 8'h08, 1, 4, 8'h01};
      vecs[4]  = '{"or_r7_r0_r3",  8'h00, 16'h4E18, 1'b0, 3'd0, 3'd3, 3'd7, 3'b001, 1'b0, 8'h18, 1, 4, 8'h01};
      vecs[5]  = '{"slt_r4_r2_r5", 8'h00, 16'h58A8, 1'b0, 3'd2, 3'd5, 3'd4, 3'b111, 1'b0, 8'hE8, 1, 4, 8'h01};
      vecs[6]  = '{"addi_neg1",    8'h00, 16'h6DFF, 1'b0, 3'd7, 3'd7, 3'd6, 3'b010, 1'b1, 8'hFF, 1, 4, 8'h01};
      vecs[7]  = '{"addi_rd0",     8'h00, 16'h605F, 1'b0, 3'd1, 3'd3, 3'd0, 3'b010, 1'b1, 8'h1F, 1, 4, 8'h01};
      vecs[8]  = '{"beq_taken",    8'h0A, 16'h76BE, 1'b1, 3'd2, 3'd3, 3'd3, 3'b110, 1'b0, 8'hFE, 0, 3, 8'h08};
      vecs[9]  = '{"beq_not",      8'h0A, 16'h76BE, 1'b0, 3'd2, 3'd3, 3'd3, 3'b110, 1'b0, 8'hFE, 0, 3, 8'h0B};
      vecs[10] = '{"beq_wrap_bk",  8'h01, 16'h7020, 1'b1, 3'd0, 3'd0, 3'd0, 3'b110, 1'b0, 8'hE0, 0, 3, 8'hE1};
      vecs[11] = '{"beq_wrap_fw",  8'hF0, 16'h725F, 1'b1, 3'd1, 3'd1, 3'd1, 3'b110, 1'b0, 8'h1F, 0, 3, 8'h0F};
      vecs[12] = '{"nop_wrap",     8'hFF, 16'h0000, 1'b0, 3'd0, 3'd0, 3'd0, 3'b000, 1'b0, 8'h00, 0, 3, 8'h00};
      vecs[13] = '{"jmp_80",       8'h00, 16'h8080, 1'b0, 3'd2, 3'd0, 3'd0, 3'b000, 1'b0, 8'h00, 0, 2, 8'h80};
      vecs[14] = '{"undef_op9",    8'h05, 16'h9ABC, 1'b1, 3'd2, 3'd7, 3'd5, 3'b000, 1'b0, 8'hFC, 0, 3, 8'h06};

      clear_mem();

      // Reset state, observed while reset is held.
      repeat (2) @(posedge clock);
      #1;
      chk("rst.pc", pc, 0);
      chk("rst.count", instr_count, 0);
      chk("rst.halted", halted, 0);
      chk("rst.req", bus.imem_req, 0);
      chk("rst.we3", we3, 0);
      chk("rst.alu_src", alu_src, 0);
      chk("rst.ra1", ra1, 0);
      chk("rst.ra2", ra2, 0);
      chk("rst.wa3", wa3, 0);
      chk("rst.ula", ula_control, 0);
      chk("rst.imm", imm, 0);

      // Reset asserted mid-fetch drops the request without waiting for a clock.
      mem[0] = 16'h6205;
      ack_delay = 100;
      reset = 1'b1;
      run = 1'b1;
      for (int c = 0; c < 10 && !bus.imem_req; c++) begin
         @(posedge clock);
         #1;
      end
      chk("midfetch.req_up", bus.imem_req, 1);
      #2 reset = 1'b0;
      #1;
      chk("midfetch.req_drop", bus.imem_req, 0);
      chk("midfetch.we3", we3, 0);
      ack_delay = 0;
      do_reset();

      // Vector table, one instruction per step pulse.
      for (int i = 0; i < NV; i++) begin
         do_reset();
         clear_mem();
         if (vecs[i].start_pc != 8'h00) mem[0] = {8'h80, vecs[i].start_pc};
         mem[vecs[i].start_pc] = vecs[i].instr;
         zero = vecs[i].zero;
         if (vecs[i].start_pc != 8'h00) begin
            step_instr();
            chk({vecs[i].name, ".pre_pc"}, pc, vecs[i].start_pc);
         end
         base = instr_count;
         step_instr();
         chk({vecs[i].name, ".retired"}, cap_done, 1);
         chk({vecs[i].name, ".latency"}, cap_lat, vecs[i].lat);
         chk({vecs[i].name, ".ra1"}, cap_ra1, vecs[i].ra1);
         chk({vecs[i].name, ".ra2"}, cap_ra2, vecs[i].ra2);
         chk({vecs[i].name, ".wa3"}, cap_wa3, vecs[i].wa3);
         chk({vecs[i].name, ".ula"}, cap_ula, vecs[i].ula);
         chk({vecs[i].name, ".alu_src"}, cap_alu, vecs[i].alu_src);
         chk({vecs[i].name, ".imm"}, cap_imm, vecs[i].imm);
         chk({vecs[i].name, ".we3_pulses"}, cap_we, vecs[i].we_n);
         chk({vecs[i].name, ".pc"}, pc, vecs[i].pc_after);
         chk({vecs[i].name, ".count"}, instr_count, 8'(base + 8'd1));
      end
      zero = 1'b0;

      // Free-run program: ADDI, ADD, JMP 0x10, HALT.
      do_reset();
      clear_mem();
      mem[0]  = 16'h6205;
      mem[1]  = 16'h1650;
      mem[2]  = 16'h8010;
      mem[16] = 16'hF000;
      run = 1'b1;
      first_we = 0; second_we = 0; we_n = 0; halt_k = 0; bad = 0;
      wa_first = 0; imm_first = 0; pc5 = 0; cnt5 = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clock);
         #1;
         if (we3) begin
            we_n++;
            if (first_we == 0) begin
               first_we = k; wa_first = wa3; imm_first = imm;
            end else second_we = k;
         end
         if (k == 5) begin
            pc5 = pc; cnt5 = instr_count;
         end
         if (halt_k != 0 && (bus.imem_req || we3 || pc != 8'h10)) bad++;
         if (halted && halt_k == 0) halt_k = k;
      end
      chk("run.addi_we_cycle", first_we, 4);
      chk("run.addi_wa3", wa_first, 1);
      chk("run.addi_imm", imm_first, 8'h05);
      chk("run.pc_after_addi", pc5, 1);
      chk("run.count_after_addi", cnt5, 1);
      chk("run.add_we_cycle", second_we, 8);
      chk("run.we3_pulses", we_n, 2);
      chk("run.halt_cycle", halt_k, 13);
      chk("run.halt_pc", pc, 8'h10);
      chk("run.halt_count", instr_count, 3);
      chk("run.halt_quiet", bad, 0);
      reset = 1'b0;
      #1;
      chk("run.rst_halted", halted, 0);
      chk("run.rst_pc", pc, 0);
      chk("run.rst_count", instr_count, 0);
      run = 1'b0;
      @(posedge clock);
      #1 reset = 1'b1;

      // Five wait states: request and address held, IR untouched until the ack.
      do_reset();
      clear_mem();
      mem[0] = 16'h6205;
      ack_delay = 5;
      req_n = 0; bad = 0; early = 0;
      step = 1'b1;
      for (int c = 0; c < 30 && instr_count == 8'd0; c++) begin
         @(posedge clock);
         #1 step = 1'b0;
         if (bus.imem_req) begin
            req_n++;
            if (bus.imem_addr != 8'h00) bad++;
            if (wa3 != 3'd0) early++;
         end
      end
      ack_delay = 0;
      chk("wait.req_cycles", req_n, 6);
      chk("wait.addr_steady", bad, 0);
      chk("wait.ir_early", early, 0);
      chk("wait.count", instr_count, 1);
      chk("wait.wa3", wa3, 1);
      chk("wait.pc", pc, 1);

      // Step mode: idle without step, step during EXECUTE ignored, two steps retire two.
      do_reset();
      clear_mem();
      req_n = 0;
      repeat (8) begin
         @(posedge clock);
         #1 if (bus.imem_req) req_n++;
      end
      chk("step.idle_no_req", req_n, 0);
      chk("step.idle_count", instr_count, 0);
      step = 1'b1;
      @(posedge clock);
      #1 step = 1'b0;
      repeat (2) @(posedge clock);
      #1 step = 1'b1;
      @(posedge clock);
      #1 step = 1'b0;
      req_n = 0;
      repeat (10) begin
         @(posedge clock);
         #1 if (bus.imem_req) req_n++;
      end
      chk("step.ignored_req", req_n, 0);
      chk("step.first_count", instr_count, 1);
      step = 1'b1;
      @(posedge clock);
      #1 step = 1'b0;
      repeat (12) @(posedge clock);
      #1;
      chk("step.second_count", instr_count, 2);
      chk("step.second_pc", pc, 2);

      // Dropping run finishes the instruction in flight, then idles.
      do_reset();
      clear_mem();
      run = 1'b1;
      for (int c = 0; c < 30 && instr_count != 8'd2; c++) begin
         @(posedge clock);
         #1;
      end
      run = 1'b0;
      repeat (20) @(posedge clock);
      #1;
      chk("runoff.count", instr_count, 3);
      chk("runoff.pc", pc, 3);
      chk("runoff.req", bus.imem_req, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
